// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bist_pkg
// Description : Shared state encoding and arithmetic helpers for the
//               multi-channel BIST sequencer.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
package bist_pkg;

    // Sequencer state encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_setup = 2'd1;
    localparam logic [1:0] c_st_run   = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    // Number of set bits in a vector of up to 32 channels
    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    // a + b clamped to lim; computed one bit wider so the sum cannot wrap
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] s;
        logic [31:0] r;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, lim}) begin
            r = lim;
        end else begin
            r = s[31:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : W-bit accumulator that clamps at 2^W-1 instead of wrapping.
//               Synchronous clear takes priority over increment.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module sat_counter
    import bist_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc_en,
    input  logic [W-1:0] inc_amt,
    output logic [W-1:0] count
);

    localparam logic [32:0] c_lim = (33'd1 << W) - 33'd1;

    logic [W-1:0] r_count;
    logic [W-1:0] w_next;

    assign w_next = W'(sat_add(32'(r_count), 32'(inc_amt), c_lim[31:0]));

    // Accumulate with clamping while enabled; a clear restarts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc_en) begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/bist_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bist_sequencer
// Description : Multi-channel BIST run controller. IDLE -> SETUP (TPG held in
//               reset) -> RUN (pattern sets, ORA fail counting) -> DONE with
//               verdict. Saturating per-channel and total error counters,
//               sticky fail map, early abort on error threshold and optional
//               TPG restart on any ORA fail.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int N_CHAN          = 4,
    parameter int ERR_BITS        = 8,
    parameter int SETUP_DELAY     = 3,
    parameter int NUM_SETS        = 1,
    parameter int MAX_ERR         = 0,
    parameter int RESTART_ON_FAIL = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         tpg_end,
    input  logic [N_CHAN-1:0]            ora_fail,
    output logic                         tpg_reset,
    output logic                         tpg_en,
    output logic                         fil_inc,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         aborted,
    output logic [N_CHAN-1:0]            fail_map,
    output logic [ERR_BITS-1:0]          err_total,
    output logic [N_CHAN*ERR_BITS-1:0]   err_chan
);

    localparam logic [32:0] c_err_lim = (33'd1 << ERR_BITS) - 33'd1;

    logic [1:0]          r_state;
    logic [7:0]          r_setup_cnt;
    logic [7:0]          r_set_cnt;
    logic                r_aborted;
    logic                r_pass;
    logic [N_CHAN-1:0]   r_fail_map;

    logic                w_in_run;
    logic                w_clear;
    logic                w_any_fail;
    logic [ERR_BITS-1:0] w_pop_amt;
    logic [ERR_BITS-1:0] w_err_total;
    logic [ERR_BITS-1:0] w_total_next;
    logic                w_err_trip;
    logic                w_last_set;

    assign w_in_run   = (r_state == c_st_run);
    assign w_clear    = ((r_state == c_st_idle) || (r_state == c_st_done)) && start;
    assign w_any_fail = |ora_fail;

    // Popcount clamped to the counter range so a narrow counter never wraps
    assign w_pop_amt  = ERR_BITS'(sat_add(32'd0, popcount(32'(ora_fail)), c_err_lim[31:0]));

    // Total as it will be after this cycle's fails, used for verdict and threshold
    assign w_total_next = ERR_BITS'(sat_add(32'(w_err_total), 32'(w_pop_amt), c_err_lim[31:0]));
    assign w_err_trip   = (MAX_ERR != 0) && (32'(w_total_next) >= 32'(MAX_ERR));
    assign w_last_set   = tpg_end && (r_set_cnt == 8'(NUM_SETS - 1));

    // One counter per channel plus the total counter fed by the popcount
    genvar gi;
    for (gi = 0; gi <= N_CHAN; gi++) begin : g_cnt
        if (gi < N_CHAN) begin : g_chan
            sat_counter #(.W(ERR_BITS)) u_chan_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (w_clear),
                .inc_en  (w_in_run),
                .inc_amt (ERR_BITS'(ora_fail[gi])),
                .count   (err_chan[gi*ERR_BITS +: ERR_BITS])
            );
        end else begin : g_total
            sat_counter #(.W(ERR_BITS)) u_total_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (w_clear),
                .inc_en  (w_in_run),
                .inc_amt (w_pop_amt),
                .count   (w_err_total)
            );
        end
    end

    // Sequencer FSM: setup timing, set counting, termination and verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_setup_cnt <= '0;
            r_set_cnt   <= '0;
            r_aborted   <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_state     <= c_st_setup;
                        r_setup_cnt <= '0;
                        r_set_cnt   <= '0;
                        r_aborted   <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end
                c_st_setup: begin
                    if (abort) begin
                        r_state   <= c_st_done;
                        r_aborted <= 1'b1;
                        r_pass    <= 1'b0;
                    end else if (r_setup_cnt == 8'(SETUP_DELAY - 1)) begin
                        r_state <= c_st_run;
                    end else begin
                        r_setup_cnt <= r_setup_cnt + 8'd1;
                    end
                end
                c_st_run: begin
                    if (tpg_end) begin
                        r_set_cnt <= r_set_cnt + 8'd1;
                    end
                    if (abort || w_err_trip) begin
                        r_state   <= c_st_done;
                        r_aborted <= 1'b1;
                        r_pass    <= 1'b0;
                    end else if (w_last_set) begin
                        r_state <= c_st_done;
                        r_pass  <= (w_total_next == '0);
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Sticky per-channel fail flags, collected only during RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_map <= '0;
        end else if (w_clear) begin
            r_fail_map <= '0;
        end else if (w_in_run) begin
            r_fail_map <= r_fail_map | ora_fail;
        end
    end

    // TPG reset is held outside RUN; in RUN it optionally pulses on any fail
    assign tpg_reset = ~w_in_run | ((RESTART_ON_FAIL != 0) & w_any_fail);
    assign tpg_en    = w_in_run;
    assign fil_inc   = w_in_run & (tpg_end | w_any_fail);
    assign busy      = (r_state == c_st_setup) || (r_state == c_st_run);
    assign done      = (r_state == c_st_done);
    assign pass      = r_pass;
    assign aborted   = r_aborted;
    assign fail_map  = r_fail_map;
    assign err_total = w_err_total;

endmodule
`default_nettype wire
